// File: rtl/icache_responder.sv
// icache_responder: direct-mapped one-word-per-line instruction cache; ICACHE_STATS_EN adds hit/miss counters
module icache_responder #(
    parameter int NSETS = 16,
    localparam int IDX_W = $clog2(NSETS),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    typedef enum logic {IDLE, FILL} state_t;
    state_t             state_q, state_d;
    logic [31:2]        miss_addr_q, miss_addr_d;
    logic [NSETS-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_mem [NSETS];
    logic [31:0]        data_mem [NSETS];
    logic [IDX_W-1:0]   idx, fill_idx;
    logic [TAG_W-1:0]   tag, fill_tag;
    logic               hit, fill_done;
    logic               unused;
    assign unused = &{1'b0, imemaddr[1:0]};
    always_comb begin
        idx       = imemaddr[IDX_W+1:2];
        tag       = imemaddr[31:IDX_W+2];
        fill_idx  = miss_addr_q[IDX_W+1:2];
        fill_tag  = miss_addr_q[31:IDX_W+2];
        hit       = (state_q == IDLE) && imemREN && !flush && valid_q[idx] && (tag_mem[idx] == tag);
        ihit      = hit;
        imemload  = hit ? data_mem[idx] : '0;
        iREN      = (state_q == FILL);
        iaddr     = {miss_addr_q, 2'b00};
        fill_done = (state_q == FILL) && !iwait;
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        valid_d     = flush ? '0 : valid_q;
        if (state_q == IDLE && imemREN && !hit && !flush) begin
            miss_addr_d = imemaddr[31:2];
            state_d     = FILL;
        end
        if (fill_done) begin
            state_d = IDLE;
            // a flush landing on the completing cycle leaves the new line invalid
            if (!flush) valid_d[fill_idx] = 1'b1;
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
        end
    end
    always_ff @(posedge CLK) begin
        if (!RST && fill_done) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iload;
        end
    end
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
    always_comb begin
        hit_count_d  = (ihit && ~&hit_count_q) ? hit_count_q + 32'd1 : hit_count_q;
        miss_count_d = (state_q == IDLE && state_d == FILL && ~&miss_count_q) ? miss_count_q + 32'd1 : miss_count_q;
        hit_count    = hit_count_q;
        miss_count   = miss_count_q;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end
`endif
endmodule
